reg_group_p: RTL and testbench
==============================

// Module: reg_group_p
// PURPOSE
//  Parametrised general-purpose register file with two async read ports (s, d)
//  and one synchronous write port addressed by dr. Per-register busy scoreboard:
//  control locks a destination at issue, the write-back clears it, and busy flags
//  for the addressed registers drive stall logic. Sits between decode and ALU/bus.
// PARAMETERS
//  DW    8   data width of each register and of i/s/d
//  NREG  4   number of registers, 2..256
//  AW    $clog2(NREG)  address width (derived, not overridden)
// PORTS
//  clk       in   1     clock; all state updates on rising edge
//  rst_n     in   1     asynchronous active-low reset
//  we        in   1     write enable; writes i into register dr
//  sr        in   AW    source read address -> s
//  dr        in   AW    destination read address -> d; also write address
//  i         in   DW    write data
//  lock      in   1     set busy bit of register lock_addr
//  lock_addr in   AW    register to lock
//  s         out  DW    contents of register sr
//  d         out  DW    contents of register dr
//  s_busy    out  1     busy bit of register sr
//  d_busy    out  1     busy bit of register dr
//  busy_vec  out  NREG  all busy bits, bit k = register k
// BEHAVIOUR
//  - Reset (rst_n=0, async): all registers = 0, all busy bits = 0; s/d/flags
//    follow combinationally (all 0). Reset mid-write or mid-lock discards both.
//  - Read: s, d, s_busy, d_busy purely combinational from current state; 0 cycles.
//  - Write: we=1 at rising edge -> reg[dr] <= i; visible on s/d the next cycle.
//    Write also clears busy[dr]. Write to a non-busy register is legal.
//  - Lock: lock=1 at rising edge -> busy[lock_addr] <= 1. Locking an already busy
//    register is a no-op (stays 1).
//  - Simultaneous write and lock, same register: data written AND busy stays 1
//    (new owner wins over retiring owner). Different registers: both take effect.
//  - Address >= NREG (NREG not power of 2): reads return 0 and busy 0; writes and
//    locks to it are ignored.
//  - sr == dr: s and d return the same value; s_busy == d_busy.
//  - No other state; no FSM beyond per-register data + busy bit.
// CONFIGURATION
//  REG_GROUP_BYPASS_EN defined: write-through forwarding; when we=1 and sr==dr
//    (resp. the dr port itself) in the same cycle, s (resp. d) outputs i instead
//    of the stored value, and s_busy/d_busy read 0 for that register unless
//    lock targets it in the same cycle. Register update timing unchanged.
//  Not defined: s/d/flags show stored state only; write visible next cycle.
// TESTING
//  1 Reset: rst_n=0 mid-cycle with we=1,dr=2,i=8'hAA -> s=d=0, busy_vec=0
//    immediately; after release reg2 reads 0.
//  2 Write/read: we=1,dr=1,i=8'h5C, next cycle sr=1 -> s=8'h5C; sr=0,dr=3 -> s=0,d=0.
//  3 Scoreboard: lock=1,lock_addr=3 -> d_busy=1 at dr=3; then we=1,dr=3,i=8'h07 ->
//    next cycle d=8'h07, d_busy=0, busy_vec=4'b0000.
//  4 Collision: busy[2]=1, same edge we=1,dr=2,i=8'h11 and lock=1,lock_addr=2 ->
//    reg2=8'h11, busy[2]=1; lock=1,lock_addr=0 with write dr=2 -> busy_vec=4'b0001.
//  5 Bypass (macro on): we=1,dr=1,sr=1,i=8'h3E same cycle -> s=d=8'h3E
//    combinationally; macro off -> s=d=old reg1 until next edge.
//  6 Params DW=16,NREG=6: write 16'hBEEF to reg5 reads back; lock/write addr 7
//    ignored, read addr 7 -> 0, busy 0.

Source files
------------

// File: rtl/reg_group_p.sv
// reg_group_p: register file, 2 async reads, 1 sync write, busy scoreboard.
// Ports: clk rst_n we sr dr i lock lock_addr / s d s_busy d_busy busy_vec.
// Optional REG_GROUP_BYPASS_EN: write-through forwarding onto s/d.
module reg_group_p #(
  parameter int DW = 8,
  parameter int NREG = 4,
  localparam int AW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] sr,
  input  logic [AW-1:0] dr,
  input  logic [DW-1:0] i,
  input  logic          lock,
  input  logic [AW-1:0] lock_addr,
  output logic [DW-1:0] s,
  output logic [DW-1:0] d,
  output logic          s_busy,
  output logic          d_busy,
  output logic [NREG-1:0] busy_vec
);

  logic [DW-1:0]   regs [NREG];
  logic [NREG-1:0] busy;
  logic            s_ok;
  logic            d_ok;

  assign s_ok = int'(sr) < NREG;
  assign d_ok = int'(dr) < NREG;
  assign busy_vec = busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) begin
        regs[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NREG; k++) begin
        if (we && dr == AW'(k)) begin
          regs[k] <= i;
        end
      end
    end
  end

  // Lock is applied after the write clear so a new owner
  // keeps the register busy over the retiring one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      for (int k = 0; k < NREG; k++) begin
        if (lock && lock_addr == AW'(k)) begin
          busy[k] <= 1'b1;
        end else if (we && dr == AW'(k)) begin
          busy[k] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    s      = '0;
    d      = '0;
    s_busy = 1'b0;
    d_busy = 1'b0;
    if (s_ok) begin
      s      = regs[sr];
      s_busy = busy[sr];
    end
    if (d_ok) begin
      d      = regs[dr];
      d_busy = busy[dr];
    end
`ifdef REG_GROUP_BYPASS_EN
    // Forwarding is held off in reset so outputs stay 0.
    if (rst_n && we && d_ok) begin
      d      = i;
      d_busy = lock && (lock_addr == dr);
      if (sr == dr) begin
        s      = i;
        s_busy = lock && (lock_addr == sr);
      end
    end
`endif
  end

endmodule

// File: tb/tb_reg_group_p.sv
// tb_reg_group_p: directed scoreboard bench for reg_group_p.
// Instance a: DW=8,NREG=4. Instance b: DW=16,NREG=6.
module tb_reg_group_p;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       we, lock;
  logic [1:0] sr, dr, la;
  logic [7:0] i, s, d;
  logic       s_busy, d_busy;
  logic [3:0] bv;

  logic        b_we, b_lock;
  logic [2:0]  b_sr, b_dr, b_la;
  logic [15:0] b_i, b_s, b_d;
  logic        b_sb, b_db;
  logic [5:0]  b_bv;

  reg_group_p #(.DW(8), .NREG(4)) u_a (
    .clk(clk), .rst_n(rst_n), .we(we), .sr(sr), .dr(dr),
    .i(i), .lock(lock), .lock_addr(la), .s(s), .d(d),
    .s_busy(s_busy), .d_busy(d_busy), .busy_vec(bv)
  );

  reg_group_p #(.DW(16), .NREG(6)) u_b (
    .clk(clk), .rst_n(rst_n), .we(b_we), .sr(b_sr),
    .dr(b_dr), .i(b_i), .lock(b_lock), .lock_addr(b_la),
    .s(b_s), .d(b_d), .s_busy(b_sb), .d_busy(b_db),
    .busy_vec(b_bv)
  );

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] observe(int sel);
    case (sel)
      0: return 32'(s);
      1: return 32'(d);
      2: return 32'(s_busy);
      3: return 32'(d_busy);
      4: return 32'(bv);
      5: return 32'(b_s);
      6: return 32'(b_d);
      7: return 32'(b_sb);
      8: return 32'(b_db);
      9: return 32'(b_bv);
      default: return 32'hdead_beef;
    endcase
  endfunction

  task automatic push(string tag, int sel, logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.sel = sel;
    x.exp = e;
    q.push_back(x);
  endtask

  task automatic chk();
    exp_t x;
    logic [31:0] obs;
    #1;
    while (q.size() > 0) begin
      x = q.pop_front();
      obs = observe(x.sel);
      checks++;
      assert (obs === x.exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h",
               x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    we = 0; lock = 0; sr = 0; dr = 0; la = 0; i = 0;
    b_we = 0; b_lock = 0; b_sr = 0; b_dr = 0;
    b_la = 0; b_i = 0;
    #12 rst_n = 1'b1;
    tick();
    push("rst_s", 0, 0);
    push("rst_d", 1, 0);
    push("rst_bv", 4, 0);
    chk();

    // give state something to lose on reset
    we = 1; dr = 2; i = 8'h55; lock = 1; la = 1;
    tick();
    we = 0; lock = 0; sr = 2;
    push("pre_s", 0, 32'h55);
    push("pre_bv", 4, 32'b0010);
    chk();

    // 1: async reset mid-cycle with write pending
    we = 1; dr = 2; i = 8'hAA;
    #2 rst_n = 1'b0;
    push("arst_s", 0, 0);
    push("arst_d", 1, 0);
    push("arst_bv", 4, 0);
    chk();
    tick();
    we = 0;
    #2 rst_n = 1'b1;
    tick();
    sr = 2; dr = 2;
    push("rel_s2", 0, 0);
    push("rel_d2", 1, 0);
    chk();

    // 2: write then read
    we = 1; dr = 1; i = 8'h5C;
    tick();
    we = 0; sr = 1;
    push("wr_s1", 0, 32'h5C);
    push("wr_d1", 1, 32'h5C);
    chk();
    sr = 0; dr = 3;
    push("rd_s0", 0, 0);
    push("rd_d3", 1, 0);
    chk();

    // 3: lock then retire
    lock = 1; la = 3;
    tick();
    lock = 0; dr = 3;
    push("lk_db3", 3, 1);
    push("lk_bv", 4, 32'b1000);
    chk();
    we = 1; dr = 3; i = 8'h07;
    tick();
    we = 0;
    push("wb_d3", 1, 32'h07);
    push("wb_db3", 3, 0);
    push("wb_bv", 4, 0);
    chk();

    // 4: write/lock collision
    lock = 1; la = 2;
    tick();
    lock = 0;
    push("lk2_bv", 4, 32'b0100);
    chk();
    we = 1; dr = 2; i = 8'h11; lock = 1; la = 2;
    tick();
    we = 0; lock = 0; sr = 2; dr = 2;
    push("col_s", 0, 32'h11);
    push("col_d", 1, 32'h11);
    push("col_sb", 2, 1);
    push("col_db", 3, 1);
    push("col_bv", 4, 32'b0100);
    chk();
    we = 1; dr = 2; i = 8'h22; lock = 1; la = 0;
    tick();
    we = 0; lock = 0;
    push("split_bv", 4, 32'b0001);
    push("split_d", 1, 32'h22);
    chk();

    // 5: same-cycle write/read
    we = 1; dr = 1; sr = 1; i = 8'h3E;
`ifdef REG_GROUP_BYPASS_EN
    push("byp_s", 0, 32'h3E);
    push("byp_d", 1, 32'h3E);
`else
    push("byp_s", 0, 32'h5C);
    push("byp_d", 1, 32'h5C);
`endif
    chk();
    tick();
    we = 0;
    push("post_s", 0, 32'h3E);
    push("post_d", 1, 32'h3E);
    chk();

    // 6: wide, non-power-of-2 instance
    b_we = 1; b_dr = 5; b_i = 16'hBEEF;
    tick();
    b_we = 0; b_sr = 5;
    push("b_s5", 5, 32'hBEEF);
    chk();
    b_we = 1; b_dr = 7; b_i = 16'h1234;
    b_lock = 1; b_la = 7;
    tick();
    b_dr = 6; b_la = 6;
    tick();
    b_we = 0; b_lock = 0;
    b_sr = 7; b_dr = 6;
    push("b_bv", 9, 0);
    push("b_s7", 5, 0);
    push("b_sb7", 7, 0);
    push("b_d6", 6, 0);
    push("b_db6", 8, 0);
    chk();
    b_sr = 5;
    push("b_keep5", 5, 32'hBEEF);
    chk();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
